logic_unit_arbiter: RTL and testbench



---
 rtl/lu_pkg.sv | 22 ++
 rtl/logic_unit_arbiter_if.sv | 32 +++
 rtl/nand_logic_16.sv | 40 ++++
 rtl/logic_unit_arbiter.sv | 142 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lu_pkg.sv
// Shared definitions for the logic unit arbiter cluster.
//   lu_op_e    : opcode encoding of the shared bitwise logic unit
//   lu_state_e : arbiter sequencing states (grant, execute, respond)
//   LU_W       : default operand/result width
package lu_pkg;

  localparam int unsigned LU_W = 16;

  typedef enum logic [1:0] {
    LU_OR   = 2'b00,
    LU_AND  = 2'b01,
    LU_NAND = 2'b10,
    LU_XOR  = 2'b11
  } lu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } lu_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between NREQ requesters and the logic unit arbiter.
//   req/op/a/b : per-requester request level, opcode and operands (packed, requester i at slot i)
//   gnt        : one-hot grant pulse
//   rsp_*      : valid/ready result channel tagged with the owning requester index
// Modports: master = requesters and result consumer, slave = arbiter.
interface logic_unit_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] a;
  logic [W*NREQ-1:0] b;
  logic [NREQ-1:0]   gnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_y;

  modport master (
    output req, op, a, b, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_y
  );

  modport slave (
    input  req, op, a, b, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_y
  );

endinterface

// File: rtl/nand_logic_16.sv
// Combinational bitwise logic unit built from two-input NAND terms only.
//   op_i : opcode (OR, AND, NAND, XOR)
//   a_i  : operand A
//   b_i  : operand B
//   y_o  : selected result
module nand_logic_16
  import lu_pkg::*;
#(
  parameter int unsigned W = LU_W
) (
  input  lu_op_e       op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  logic [W-1:0] nab, na, nb, and_w, or_w, xa, xb, xor_w;

  assign nab   = ~(a_i & b_i);
  assign na    = ~(a_i & a_i);
  assign nb    = ~(b_i & b_i);
  assign and_w = ~(nab & nab);
  assign or_w  = ~(na & nb);
  // Classic four-NAND XOR sharing the a/b NAND term.
  assign xa    = ~(a_i & nab);
  assign xb    = ~(b_i & nab);
  assign xor_w = ~(xa & xb);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      LU_OR:   y_o = or_w;
      LU_AND:  y_o = and_w;
      LU_NAND: y_o = nab;
      LU_XOR:  y_o = xor_w;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one nand_logic_16 among NREQ requesters.
// Each operation runs grant (IDLE) -> execute (EXEC) -> respond (RESP); one in flight.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : logic_unit_arbiter_if slave (req/op/a/b in, gnt and rsp_* out, rsp_ready in)
// Build option: define LU_ARB_PRIO_EN to give requester 0 fixed absolute priority;
// the remaining requesters then share round-robin and ptr is untouched by requester-0 grants.
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = LU_W
) (
  input logic                  clk,
  input logic                  rst,
  logic_unit_arbiter_if.slave  bus
);

  localparam int unsigned IDW = $clog2(NREQ);

  lu_state_e      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_y_q, rsp_y_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  lu_op_e         op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;

  logic [W-1:0]   lu_y;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [NREQ-1:0] req_rr;
  int unsigned    cand;
  int unsigned    nxt;

  nand_logic_16 #(
    .W(W)
  ) u_logic (
    .op_i(op_q),
    .a_i (a_q),
    .b_i (b_q),
    .y_o (lu_y)
  );

  // Winner: first set request at or above ptr, wrapping modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    req_rr    = bus.req;
`ifdef LU_ARB_PRIO_EN
    req_rr[0] = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (i + 32'(ptr_q)) % NREQ;
      if (!win_found && req_rr[cand]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
`ifdef LU_ARB_PRIO_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    nxt         = (32'(win_idx) + 1) % NREQ;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          op_d           = lu_op_e'(bus.op[2*32'(win_idx) +: 2]);
          a_d            = bus.a[W*32'(win_idx) +: W];
          b_d            = bus.b[W*32'(win_idx) +: W];
          gnt_d[win_idx] = 1'b1;
          rsp_id_d       = win_idx;
          ptr_d          = nxt[IDW-1:0];
`ifdef LU_ARB_PRIO_EN
          if (win_idx == '0) ptr_d = ptr_q;
`endif
          state_d        = StExec;
        end
      end
      StExec: begin
        rsp_y_d     = lu_y;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
      ptr_q       <= '0;
      op_q        <= LU_OR;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter (NREQ=4, W=16).
module tb_logic_unit_arbiter;
  import lu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic_unit_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  logic_unit_arbiter #(
    .NREQ(NREQ),
    .W   (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [15:0] av,
                         input logic [15:0] bv);
    bus.op[2*i +: 2] = o;
    bus.a[W*i +: W]  = av;
    bus.b[W*i +: W]  = bv;
    bus.req[i]       = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req = '0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want %b", bus.gnt, 4'b0000);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", bus.rsp_id);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_y !== 16'h0000) $display("FAIL reset_y: got %h want 0000", bus.rsp_y);
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single;
    bus.rsp_ready = 1'b1;
    set_req(1, 2'b00, 16'h00F0, 16'h0F00);
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0010) $display("FAIL single_gnt: got %b want 0010", bus.gnt);
    else pass_cnt++;
    bus.req = '0;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0000) $display("FAIL single_gnt_pulse: got %b want 0000", bus.gnt);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_id !== 2'd1) $display("FAIL single_id: got %0d want 1", bus.rsp_id);
    else pass_cnt++;
    total_cnt++;
    if (bus.rsp_y !== 16'h0FF0) $display("FAIL single_y: got %h want 0ff0", bus.rsp_y);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.rsp_valid !== 1'b0) $display("FAIL single_done: got %b want 0", bus.rsp_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0000) $display("FAIL single_idle_gnt: got %b want 0000", bus.gnt);
    else pass_cnt++;
  endtask

  task automatic test_opcodes;
    logic [1:0]  ops [4];
    logic [15:0] expv[4];
    ops[0] = 2'b00; expv[0] = 16'hEEEE;
    ops[1] = 2'b01; expv[1] = 16'h8888;
    ops[2] = 2'b10; expv[2] = 16'h7777;
    ops[3] = 2'b11; expv[3] = 16'h6666;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(0, ops[k], 16'hAAAA, 16'hCCCC);
      tick();
      total_cnt++;
      if (bus.gnt !== 4'b0001) $display("FAIL opcode_gnt[%0d]: got %b want 0001", k, bus.gnt);
      else pass_cnt++;
      bus.req = '0;
      tick();
      total_cnt++;
      if (bus.rsp_y !== expv[k])
        $display("FAIL opcode_y[%0d]: got %h want %h", k, bus.rsp_y, expv[k]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_round_robin;
    logic [15:0] expv[4];
    logic [3:0]  eg;
    int          id;
    expv[0] = 16'hEEEE; expv[1] = 16'h8888; expv[2] = 16'h7777; expv[3] = 16'h6666;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, i[1:0], 16'hAAAA, 16'hCCCC);
    for (int k = 0; k < 5; k++) begin
`ifdef LU_ARB_PRIO_EN
      id = 0;
`else
      id = k % 4;
`endif
      eg = '0;
      eg[id] = 1'b1;
      tick();
      total_cnt++;
      if (bus.gnt !== eg) $display("FAIL rr_gnt[%0d]: got %b want %b", k, bus.gnt, eg);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({bus.rsp_id, bus.rsp_y} !== {id[1:0], expv[id]})
        $display("FAIL rr_rsp[%0d]: got id %0d y %h want id %0d y %h", k, bus.rsp_id,
                 bus.rsp_y, id, expv[id]);
      else pass_cnt++;
      tick();
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    set_req(2, 2'b11, 16'hFF00, 16'h0FF0);
    set_req(3, 2'b01, 16'hFF00, 16'h0FF0);
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0100) $display("FAIL bp_gnt: got %b want 0100", bus.gnt);
    else pass_cnt++;
    bus.req[2] = 1'b0;
    tick();
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y} !== {1'b1, 2'd2, 16'hF0F0})
      $display("FAIL bp_first: got v %b id %0d y %h want v 1 id 2 y f0f0", bus.rsp_valid,
               bus.rsp_id, bus.rsp_y);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      tick();
      total_cnt++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.gnt} !== {1'b1, 2'd2, 16'hF0F0, 4'b0000})
        $display("FAIL bp_stall[%0d]: got v %b id %0d y %h gnt %b want v 1 id 2 y f0f0 gnt 0000",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.gnt);
      else pass_cnt++;
    end
    bus.rsp_ready = 1'b1;
    tick();
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_y} !== {1'b0, 16'hF0F0})
      $display("FAIL bp_release: got v %b y %h want v 0 y f0f0", bus.rsp_valid, bus.rsp_y);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b1000) $display("FAIL bp_next_gnt: got %b want 1000", bus.gnt);
    else pass_cnt++;
    bus.req[3] = 1'b0;
    tick();
    total_cnt++;
    if ({bus.rsp_id, bus.rsp_y} !== {2'd3, 16'h0F00})
      $display("FAIL bp_next_rsp: got id %0d y %h want id 3 y 0f00", bus.rsp_id, bus.rsp_y);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(1, 2'b00, 16'h1234, 16'h0000);
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0010) $display("FAIL rstmid_gnt: got %b want 0010", bus.gnt);
    else pass_cnt++;
    bus.req = '0;
    tick();
    total_cnt++;
    if (bus.rsp_valid !== 1'b1) $display("FAIL rstmid_resp: got %b want 1", bus.rsp_valid);
    else pass_cnt++;
    tick();
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_y} !== {4'b0000, 1'b0, 16'h0000})
      $display("FAIL rstmid_async: got gnt %b v %b y %h want gnt 0000 v 0 y 0000", bus.gnt,
               bus.rsp_valid, bus.rsp_y);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'b01, 16'hFFFF, 16'h00FF);
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0001) $display("FAIL rstmid_first_gnt: got %b want 0001", bus.gnt);
    else pass_cnt++;
    bus.req = '0;
    tick();
    tick();
  endtask

  task automatic test_isolation;
    bus.rsp_ready = 1'b1;
    set_req(0, 2'b01, 16'h0001, 16'h00FF);
    tick();
    total_cnt++;
    if (bus.gnt !== 4'b0001) $display("FAIL iso_gnt: got %b want 0001", bus.gnt);
    else pass_cnt++;
    bus.a[15:0] = 16'hFFFF;
    bus.req = '0;
    tick();
    total_cnt++;
    if (bus.rsp_y !== 16'h0001) $display("FAIL iso_y: got %h want 0001", bus.rsp_y);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_opcodes();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_isolation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
